// File: rtl/dropout_lanes_if.sv
// Stream bus for dropout_lanes: the input beat channel and the output beat/mask channel.
interface dropout_lanes_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
);
    // Both channels: a beat transfers on a rising clk edge where valid & ready are both 1;
    // once valid is raised the sender holds valid and its payload stable until that edge.
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*DATA_WIDTH-1:0]   out_data;
    logic [LANES-1:0]              out_mask;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_mask
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_mask
    );
endinterface

// File: rtl/dropout_lanes.sv
// Multi-lane inverted dropout: per-lane Galois LFSR drop decision, keep scaling with saturation.
// Optional DROPOUT_STATS_EN adds stats_clear / drop_count (saturating dropped-lane counter).
module dropout_lanes #(
    parameter int          DATA_WIDTH  = 8,
    parameter int          LANES       = 4,
    parameter int          LFSR_WIDTH  = 32,
    parameter int          SCALE_WIDTH = 16,
    parameter int          FRAC_BITS   = 8,
    parameter logic [31:0] RESET_SEED  = 32'h0000_0001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   training_mode,
    input  logic [15:0]            drop_thresh,
    input  logic [SCALE_WIDTH-1:0] scale,
    input  logic                   seed_load,
    input  logic [31:0]            seed_in,
`ifdef DROPOUT_STATS_EN
    input  logic                   stats_clear,
    output logic [31:0]            drop_count,
`endif
    dropout_lanes_if.slave         bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = DATA_WIDTH + SCALE_WIDTH;
    localparam int BW = LANES * DATA_WIDTH;

    generate
        if (LFSR_WIDTH != 32) begin : g_bad_lfsr_width
            $error("dropout_lanes: LFSR_WIDTH must be 32");
        end
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $error("dropout_lanes: LANES must be in 1..16");
        end
    endgenerate

    function automatic logic [LFSR_WIDTH-1:0] lane_seed(input logic [31:0] base, input int idx);
        logic [31:0] v;
        v = base ^ (idx * 32'h9E37_79B9);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    logic                   s1_adv;
    logic                   in_ready_w;
    logic                   hs;

    logic                   s1_valid_q;
    logic                   s1_train_q;
    logic [BW-1:0]          s1_data_q;
    logic [SCALE_WIDTH-1:0] s1_scale_q;
    logic [LANES-1:0]       s1_mask_q;

    logic                   s2_valid_q;
    logic [BW-1:0]          s2_data_q;
    logic [LANES-1:0]       s2_mask_q;

    logic [LFSR_WIDTH-1:0]  lfsr_q [LANES];
    logic [LFSR_WIDTH-1:0]  lfsr_d [LANES];
    logic [LANES-1:0]       mask_d;
    logic [BW-1:0]          res_d;
    logic [PW-1:0]          prod;
    logic [PW-1:0]          shifted;

    assign s1_adv     = !s2_valid_q || bus.out_ready;
    // Held low for the whole time rst is asserted, independent of pipeline state.
    assign in_ready_w = !rst && (!s1_valid_q || s1_adv);
    assign hs         = bus.in_valid && in_ready_w;

    // Mask uses the current (pre-advance, pre-reload) LFSR state of the accepted beat.
    always_comb begin
        mask_d = '0;
        lfsr_d = lfsr_q;
        for (int i = 0; i < LANES; i++) begin
            mask_d[i] = !training_mode || (lfsr_q[i][15:0] >= drop_thresh);
            if (seed_load) begin
                lfsr_d[i] = lane_seed(seed_in, i);
            end else if (hs && training_mode) begin
                lfsr_d[i] = lfsr_step(lfsr_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                lfsr_q[i] <= lane_seed(RESET_SEED, i);
            end
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        res_d   = '0;
        prod    = '0;
        shifted = '0;
        for (int i = 0; i < LANES; i++) begin
            prod    = PW'(s1_data_q[i*DW +: DW]) * PW'(s1_scale_q);
            shifted = prod >> FRAC_BITS;
            if (!s1_train_q) begin
                res_d[i*DW +: DW] = s1_data_q[i*DW +: DW];
            end else if (!s1_mask_q[i]) begin
                res_d[i*DW +: DW] = '0;
            end else if (|shifted[PW-1:DW]) begin
                res_d[i*DW +: DW] = '1;
            end else begin
                res_d[i*DW +: DW] = shifted[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_train_q <= 1'b0;
            s1_data_q  <= '0;
            s1_scale_q <= '0;
            s1_mask_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mask_q  <= '0;
        end else begin
            if (in_ready_w) begin
                s1_valid_q <= bus.in_valid;
            end
            if (hs) begin
                s1_data_q  <= bus.in_data;
                s1_train_q <= training_mode;
                s1_scale_q <= scale;
                s1_mask_q  <= mask_d;
            end
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            // Output payload only changes when a new beat moves in, so it is held under stall.
            if (s1_adv && s1_valid_q) begin
                s2_data_q <= res_d;
                s2_mask_q <= s1_mask_q;
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_mask  = s2_mask_q;

`ifdef DROPOUT_STATS_EN
    logic [31:0] drop_count_q;
    logic [4:0]  zeros;
    logic [32:0] drop_sum;

    always_comb begin
        zeros = '0;
        for (int i = 0; i < LANES; i++) begin
            zeros = zeros + {4'b0000, !s2_mask_q[i]};
        end
        drop_sum = {1'b0, drop_count_q} + 33'(zeros);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q <= '0;
        end else if (stats_clear) begin
            drop_count_q <= '0;
        end else if (s2_valid_q && bus.out_ready) begin
            drop_count_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end

    assign drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_dropout_lanes.sv
// Directed and table-driven bench for dropout_lanes with an LFSR reference model and scoreboard.
`timescale 1ns/1ps
module tb_dropout_lanes;
    localparam int DW    = 8;
    localparam int LANES = 4;
    localparam int BW    = DW * LANES;
    localparam int EW    = BW + LANES;
    localparam logic [31:0] RESET_SEED = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        training_mode = 1'b0;
    logic [15:0] drop_thresh = 16'h0;
    logic [15:0] scale = 16'h0100;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = 32'h0;
`ifdef DROPOUT_STATS_EN
    logic        stats_clear = 1'b0;
    logic [31:0] drop_count;
`endif

    dropout_lanes_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus ();

    dropout_lanes #(
        .DATA_WIDTH(DW), .LANES(LANES), .LFSR_WIDTH(32),
        .SCALE_WIDTH(16), .FRAC_BITS(8), .RESET_SEED(RESET_SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .training_mode(training_mode),
        .drop_thresh(drop_thresh),
        .scale(scale),
        .seed_load(seed_load),
        .seed_in(seed_in),
`ifdef DROPOUT_STATS_EN
        .stats_clear(stats_clear),
        .drop_count(drop_count),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference model
    logic [31:0]    m_lfsr [LANES];
    logic [EW-1:0]  exp_q [$];
    int             kept_lanes = 0;
    int             seen_lanes = 0;
    bit             count_en = 1'b0;
    longint         model_drops = 0;

    function automatic logic [31:0] m_seed(input logic [31:0] b, input int i);
        logic [31:0] v;
        v = b ^ (32'(i) * 32'h9E37_79B9);
        if (v == 32'h0) v = 32'h1;
        return v;
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic model_reseed(input logic [31:0] b);
        for (int i = 0; i < LANES; i++) m_lfsr[i] = m_seed(b, i);
    endtask

    function automatic logic [EW-1:0] model_beat(input logic [BW-1:0] d, input logic tr,
                                                 input logic [15:0] th, input logic [15:0] sc);
        logic [BW-1:0]    r;
        logic [LANES-1:0] k;
        logic [7:0]       dv;
        int unsigned      p;
        r = '0;
        k = '0;
        for (int i = 0; i < LANES; i++) begin
            dv   = d[i*DW +: DW];
            k[i] = !tr || (m_lfsr[i][15:0] >= th);
            if (!tr) begin
                r[i*DW +: DW] = dv;
            end else if (k[i]) begin
                p = 32'(dv) * 32'(sc);
                p = p >> 8;
                r[i*DW +: DW] = (p > 255) ? 8'hFF : p[7:0];
            end
        end
        return {k, r};
    endfunction

    // Scoreboard: inputs and outputs sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            model_reseed(RESET_SEED);
            exp_q.delete();
            model_drops = 0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    note_fail("sb_unexpected_out");
                end else begin
                    check("sb_out", {28'h0, bus.out_mask, bus.out_data}, {28'h0, exp_q[0]});
                    if (bus.out_ready) begin
                        e = exp_q.pop_front();
                        model_drops += LANES - $countones(e[EW-1:BW]);
                        if (count_en) begin
                            kept_lanes += $countones(bus.out_mask);
                            seen_lanes += LANES;
                        end
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model_beat(bus.in_data, training_mode, drop_thresh, scale));
                if (training_mode) begin
                    for (int i = 0; i < LANES; i++) m_lfsr[i] = m_step(m_lfsr[i]);
                end
            end
            if (seed_load) model_reseed(seed_in);
        end
    end

    // Driver tasks: called at posedge+1, return at posedge+1 after the accepting edge.
    task automatic drive_beat(input logic [BW-1:0] d, input logic tr, input logic [15:0] th,
                              input logic [15:0] sc, input logic sl);
        int budget;
        budget = 50;
        bus.in_data   = d;
        training_mode = tr;
        drop_thresh   = th;
        scale         = sc;
        seed_load     = sl;
        bus.in_valid  = 1'b1;
        do begin
            @(negedge clk);
            budget--;
        end while (!bus.in_ready && budget > 0);
        if (!bus.in_ready) note_fail("in_ready_timeout");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        seed_load    = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [BW-1:0] ed,
                              input logic [LANES-1:0] em, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        check({name, "_lat"}, 64'(n), 64'(lat));
        check({name, "_data"}, 64'(bus.out_data), 64'(ed));
        check({name, "_mask"}, 64'(bus.out_mask), 64'(em));
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n, input int stall_pct, input bit rand_ctrl,
                              input logic [15:0] th, input logic [15:0] sc);
        int sent;
        int budget;
        bit vld;
        bit acc;
        sent   = 0;
        budget = 20000;
        vld    = 1'b0;
        while ((sent < n || exp_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            acc = vld && bus.in_ready;
            @(posedge clk);
            #1;
            budget--;
            if (acc) begin
                sent++;
                vld = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (!vld && sent < n && $urandom_range(0, 99) >= stall_pct) begin
                vld = 1'b1;
                bus.in_data = $urandom();
                if (rand_ctrl) begin
                    training_mode = 1'($urandom_range(0, 1));
                    drop_thresh   = 16'($urandom_range(0, 65535));
                    scale         = 16'($urandom_range(0, 1023));
                end else begin
                    training_mode = 1'b1;
                    drop_thresh   = th;
                    scale         = sc;
                end
            end
            bus.in_valid = vld;
        end
        if (budget == 0) note_fail("stream_timeout");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    typedef struct {
        logic             tr;
        logic [15:0]      th;
        logic [15:0]      sc;
        logic [BW-1:0]    d;
        logic [BW-1:0]    ed;
        logic [LANES-1:0] em;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 16'h0000, 16'h0100, 32'h0403_0201, 32'h0403_0201, 4'hF};
        vecs[1] = '{1'b1, 16'h0000, 16'h0200, 32'h007F_9050, 32'h00FE_FFA0, 4'hF};
        vecs[2] = '{1'b1, 16'h0000, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'hF};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 32'h80FF_7F01, 32'h80FF_7F01, 4'hF};
        vecs[4] = '{1'b1, 16'h0000, 16'h0180, 32'h01AA_2010, 32'h01FF_3018, 4'hF};
        vecs[5] = '{1'b1, 16'h0000, 16'h0080, 32'h03FF_8001, 32'h017F_4000, 4'hF};
        vecs[6] = '{1'b1, 16'h0000, 16'hFFFF, 32'h0000_0001, 32'h0000_00FF, 4'hF};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        model_reseed(RESET_SEED);

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'h0);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_out_data", 64'(bus.out_data), 64'h0);
        check("rst_out_mask", 64'(bus.out_mask), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 64'(bus.in_ready), 64'h1);
        @(posedge clk);
        #1;

        // Directed vectors: pass-through, scaling, saturation, scale=0, inference ignores thresh
        for (int v = 0; v < 7; v++) begin
            drive_beat(vecs[v].d, vecs[v].tr, vecs[v].th, vecs[v].sc, 1'b0);
            expect_out($sformatf("vec%0d", v), vecs[v].ed, vecs[v].em, 2);
        end

        // drop_thresh = FFFF: almost all lanes dropped, checked against the model
        run_stream(8, 0, 1'b0, 16'hFFFF, 16'h0100);

        // 1000 beats at thresh 0x8000, full throughput; kept fraction near one half
        kept_lanes = 0;
        seen_lanes = 0;
        count_en   = 1'b1;
        run_stream(1000, 0, 1'b0, 16'h8000, 16'h0100);
        count_en   = 1'b0;
        check("kept_frac", 64'((kept_lanes * 100 >= seen_lanes * 45) &&
                               (kept_lanes * 100 <= seen_lanes * 55) && seen_lanes == 4000), 64'h1);

        // Back-pressure with randomized per-beat controls
        run_stream(500, 30, 1'b1, 16'h0, 16'h0100);

        // seed_load with seed 0: lane masks for thresh 0x8000 are {drop, keep, drop, drop}
        seed_in   = 32'h0;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        drive_beat(32'h4433_2211, 1'b1, 16'h8000, 16'h0100, 1'b0);
        expect_out("seed0_first", 32'h0033_0000, 4'b0100, 2);
        run_stream(9, 0, 1'b0, 16'h8000, 16'h0100);
        // A beat accepted together with seed_load still uses the old state
        drive_beat(32'h5566_7788, 1'b1, 16'h8000, 16'h0100, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        drive_beat(32'h4433_2211, 1'b1, 16'h8000, 16'h0100, 1'b0);
        expect_out("seed0_repeat", 32'h0033_0000, 4'b0100, 2);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        drive_beat(32'hAAAA_AAAA, 1'b1, 16'h0000, 16'h0100, 1'b0);
        drive_beat(32'hBBBB_BBBB, 1'b1, 16'h0000, 16'h0100, 1'b0);
        check("inflight_valid", 64'(bus.out_valid), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'h0);
        check("midrst_out_data", 64'(bus.out_data), 64'h0);
        check("midrst_out_mask", 64'(bus.out_mask), 64'h0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive_beat(32'h4433_2211, 1'b1, 16'h8000, 16'h0100, 1'b0);
        expect_out("post_rst", 32'h0033_0000, 4'b0100, 2);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'h0);
`ifdef DROPOUT_STATS_EN
        check("drop_count", 64'(drop_count), 64'(model_drops));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/dropout_lanes.md
Name: dropout_lanes

Overview:
Multi-lane inverted-dropout stage for the CNN datapath; successor to the single-lane dropout block. Processes LANES activations per beat behind a valid/ready handshake, each lane with its own reseedable LFSR and a runtime drop threshold. In training mode, kept values are scaled by a runtime 1/(1-p) factor with saturation; in inference mode data passes through unscaled. Emits the per-lane keep mask alongside the data for backward-pass reuse.

Parameters:
DATA_WIDTH, 8, unsigned activation width per lane
LANES, 4, lanes per beat (1..16)
LFSR_WIDTH, 32, per-lane LFSR width (fixed 32 in this generation; other values are an elaboration error)
SCALE_WIDTH, 16, width of scale input, unsigned fixed point
FRAC_BITS, 8, fractional bits of scale
RESET_SEED, 32'h0000_0001, base seed applied at reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
training_mode  in  1  1 = drop+scale, 0 = pass-through
drop_thresh  in  16  lane drops when lfsr[15:0] < drop_thresh
scale  in  SCALE_WIDTH  keep scale, UQ(SCALE_WIDTH-FRAC_BITS).FRAC_BITS
seed_load  in  1  pulse: reseed all LFSRs from seed_in
seed_in  in  32  base seed
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*DATA_WIDTH  result lanes
out_mask  out  LANES  bit i = 1 if lane i kept

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset: all outputs 0 (in_ready 0 while rst is asserted, 1 on the first cycle after); pipeline valids cleared; lane i LFSR = RESET_SEED ^ (i * 32'h9E37_79B9), forced to 32'h1 if the result is 0.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1. Next state = lsb ? (s>>1) ^ 32'h8020_0003 : s>>1. Advances only on an input handshake (in_valid & in_ready) with training_mode=1.
- seed_load: reloads all lanes using the reset formula with seed_in. It has priority over an advance in the same cycle. The beat accepted in that cycle uses the pre-load LFSR state.
- Pipeline, 2 stages:
  - S1 registers data, training_mode, scale and mask. mask[i] = !training_mode | (lfsr_i[15:0] >= drop_thresh).
  - S2 registers the result.
- Latency: 2 cycles from handshake to out_valid when unstalled. Full throughput of 1 beat/cycle.
- Handshake:
  - s1_adv = !s2_valid | out_ready; in_ready = !s1_valid | s1_adv.
  - Data and mask are held stable while out_valid & !out_ready.
  - No beat is dropped or duplicated under any valid/ready pattern.
- Arithmetic, training mode:
  - Dropped lane outputs 0.
  - Kept lane outputs (data * scale) >> FRAC_BITS, truncated, saturated to 2^DATA_WIDTH-1.
  - Product width is DATA_WIDTH+SCALE_WIDTH.
- Arithmetic, inference mode: out = data and mask all ones, regardless of scale.
- Boundaries:
  - drop_thresh=0 never drops.
  - drop_thresh=16'hFFFF drops unless lfsr[15:0]==16'hFFFF.
  - scale=0 in training yields 0 on all lanes with mask still reported.
  - training_mode, drop_thresh and scale are sampled per beat at the input handshake; mid-stream changes affect only later beats.
- Reset mid-operation discards all in-flight beats; out_valid drops asynchronously.

Optional Feature:
DROPOUT_STATS_EN
- Defined: adds ports stats_clear (in, 1) and drop_count (out, 32).
  - drop_count adds the number of zero mask bits of each output handshake.
  - It saturates at 32'hFFFF_FFFF.
  - stats_clear zeroes it synchronously, taking priority over an increment in the same cycle.
  - Reset value is 0.
- Undefined: these ports and the counter are absent; the rest of the behaviour is identical.

Test Plan:
- Reset release, LANES=4, training_mode=0, in_data=32'h0403_0201, out_ready=1 -> out_data=32'h0403_0201, out_mask=4'hF, exactly 2 cycles after the handshake.
- training_mode=1, drop_thresh=0, scale=16'h0200, lanes {8'h50, 8'h90, 8'h7F, 8'h00} -> {8'hA0, 8'hFF (saturated), 8'hFE, 8'h00}, mask 4'hF.
- training_mode=1, drop_thresh=16'h8000, scale=16'h0100, 1000 random beats -> out_data and out_mask match the Galois LFSR reference model bit-exactly. Kept fraction is 0.5±0.05.
- Random in_valid/out_ready back-pressure (30% stall) for 500 beats -> output sequence equals the input sequence in order, with no loss or duplication. Data is held stable while stalled.
- seed_load with seed_in=32'h0 -> every lane reseeds as for seed 0 (lane 0 forced to 32'h1). The next 10 masks match the model. Repeating the same seed reproduces an identical mask sequence.
- rst asserted with 2 beats in flight -> out_valid=0 and out_data=0 immediately. After release, the first beat's mask matches a fresh-reset LFSR model.
